// File: rtl/cosine_sim_feeder.sv
// ---------------------------------------------------------------------------
// cosine_sim_feeder
//
// Collects (a[i], b[i]) element pairs from a valid/ready stream into two
// W-element vectors. It then pulses eng_start for one cycle and holds the
// vectors stable while the cosine-similarity engine computes. The engine's
// result (or a qNaN if the engine never answers) goes out on a valid/ready
// result stream with status flags.
//
// Parameters
//   W        vector length, 2..8
//   TIMEOUT  cycles allowed in WAIT before an error result, >= 3W+4
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   element-pair stream handshake
//   s_a, s_b          element of vector A / B (IEEE-754 single)
//   s_last            marks the final element of a vector
//   eng_start         one-cycle start pulse to the engine
//   eng_vec_a/_b      buffered vectors, element i at bits [32*i +: 32]
//   eng_similarity    engine result, qualified by eng_valid
//   eng_valid         engine result pulse, honoured only while waiting
//   m_valid/m_ready   result stream handshake
//   m_data            similarity value
//   m_status          bit0 = short (zero-padded) vector, bit1 = timeout
// ---------------------------------------------------------------------------
module cosine_sim_feeder #(
    parameter int W       = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [31:0]     s_a,
    input  logic [31:0]     s_b,
    input  logic            s_last,
    output logic            eng_start,
    output logic [32*W-1:0] eng_vec_a,
    output logic [32*W-1:0] eng_vec_b,
    input  logic [31:0]     eng_similarity,
    input  logic            eng_valid,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_data,
    output logic [1:0]      m_status
);

    localparam int CW = $clog2(W) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   m_data_q, m_data_d;
    logic [1:0]    m_status_q, m_status_d;
    logic          s_ready_q, eng_start_q, m_valid_q;
    logic          clear_buf;
    logic          xfer;

    // s_ready_q is only ever high in FILL, so this is the only place a
    // transfer can happen; s_valid in other states is never consumed.
    assign xfer = s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        short_d    = short_q;
        tmo_d      = tmo_q;
        m_data_d   = m_data_q;
        m_status_d = m_status_q;
        clear_buf  = 1'b0;

        case (state_q)
            S_FILL: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                    // Vector closes on s_last or on the W-th element,
                    // whichever comes first. A full vector is never "short",
                    // even when s_last was absent.
                    if (s_last || (cnt_q == CNT_LAST)) begin
                        state_d = S_START;
                        short_d = s_last && (cnt_q != CNT_LAST);
                    end
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The engine result takes priority over a coincident timeout.
                if (eng_valid) begin
                    m_data_d   = eng_similarity;
                    m_status_d = {1'b0, short_q};
                    state_d    = S_OUT;
                end else if (tmo_q == TMO_MAX) begin
                    m_data_d   = QNAN;
                    m_status_d = {1'b1, short_q};
                    state_d    = S_OUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin // S_OUT
                if (m_valid_q && m_ready) begin
                    clear_buf = 1'b1;
                    cnt_d     = '0;
                    short_d   = 1'b0;
                    state_d   = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            short_q     <= 1'b0;
            tmo_q       <= '0;
            m_data_q    <= '0;
            m_status_q  <= '0;
            s_ready_q   <= 1'b0;
            eng_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            short_q     <= short_d;
            tmo_q       <= tmo_d;
            m_data_q    <= m_data_d;
            m_status_q  <= m_status_d;
            // Handshake/strobe outputs are registered from the next state so
            // they line up with the state they describe, glitch-free.
            s_ready_q   <= (state_d == S_FILL);
            eng_start_q <= (state_d == S_START);
            m_valid_q   <= (state_d == S_OUT);
        end
    end

    // One register pair per slot. Slots not reached by a short vector keep
    // the +0.0 left by the previous clear, which is the zero padding.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_slot
            logic [31:0] a_q;
            logic [31:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (clear_buf) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (xfer && (cnt_q == CW'(gi))) begin
                    a_q <= s_a;
                    b_q <= s_b;
                end
            end

            assign eng_vec_a[32*gi +: 32] = a_q;
            assign eng_vec_b[32*gi +: 32] = b_q;
        end
    endgenerate

    assign s_ready   = s_ready_q;
    assign eng_start = eng_start_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_status  = m_status_q;

endmodule

// File: tb/tb_cosine_sim_feeder.sv
// ---------------------------------------------------------------------------
// tb_cosine_sim_feeder
//
// Random element streams are grouped into vectors by a queue-based model
// (close on last or on W elements, pad with zero). The bench plays the engine
// itself and plays the result sink. For every vector it checks the start
// pulse, the buffered vectors, the result timing, the data and status, and
// the behaviour under backpressure and across the handshake.
// ---------------------------------------------------------------------------
module tb_cosine_sim_feeder;

    localparam int          W       = 5;
    localparam int          TIMEOUT = 64;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_a;
    logic [31:0]     s_b;
    logic            s_last;
    logic            eng_start;
    logic [32*W-1:0] eng_vec_a;
    logic [32*W-1:0] eng_vec_b;
    logic [31:0]     eng_similarity;
    logic            eng_valid;
    logic            m_valid;
    logic            m_ready;
    logic [31:0]     m_data;
    logic [1:0]      m_status;

    cosine_sim_feeder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_a            (s_a),
        .s_b            (s_b),
        .s_last         (s_last),
        .eng_start      (eng_start),
        .eng_vec_a      (eng_vec_a),
        .eng_vec_b      (eng_vec_b),
        .eng_similarity (eng_similarity),
        .eng_valid      (eng_valid),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_status       (m_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          last;
    } elem_t;

    elem_t pend[$];      // element stream still to be sent
    int    n_tests = 0;
    int    n_fail  = 0;
    int    first_wait;   // negedges waited for s_ready before the first element

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Length of the vector at the head of the stream, 0 if not yet complete.
    function automatic int group_len();
        for (int i = 0; i < pend.size(); i++)
            if (pend[i].last || i == W - 1) return i + 1;
        return 0;
    endfunction

    task automatic push_segment(input int n, input bit with_last);
        elem_t e;
        for (int i = 0; i < n; i++) begin
            e.a    = $urandom;
            e.b    = $urandom;
            e.last = with_last && (i == n - 1);
            pend.push_back(e);
        end
    endtask

    task automatic present_next();
        if (pend.size() > 0) begin
            s_valid = 1'b1;
            s_a     = pend[0].a;
            s_b     = pend[0].b;
            s_last  = pend[0].last;
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    // Entered and left at a negedge; leaves right after the last transfer.
    task automatic drive_group(output logic [32*W-1:0] ea, output logic [32*W-1:0] eb,
                               output bit sh);
        int    k;
        int    g;
        elem_t e;
        ea = '0;
        eb = '0;
        sh = 1'b0;
        k  = group_len();
        check_val("group_complete", k > 0, 1);
        if (k == 0) return;
        sh = pend[k-1].last && (k < W);
        for (int i = 0; i < k; i++) begin
            e = pend.pop_front();
            ea[32*i +: 32] = e.a;
            eb[32*i +: 32] = e.b;
            s_valid = 1'b1;
            s_a     = e.a;
            s_b     = e.b;
            s_last  = e.last;
            g = 0;
            while (!s_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (i == 0) first_wait = g;
            check_val("s_ready_wait", s_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        present_next();
    endtask

    // lat > 0: engine answers lat cycles after the start cycle; lat < 0: never.
    task automatic do_vector(input int lat, input int bp, input logic [31:0] eng_val);
        logic [32*W-1:0] ea;
        logic [32*W-1:0] eb;
        bit              sh;
        logic [31:0]     exp_d;
        logic [1:0]      exp_s;
        int              bad;
        int              n_quiet;

        drive_group(ea, eb, sh);
        check_val("start_pulse", eng_start, 1);
        check_val("s_ready_start", s_ready, 0);
        check_val("vec_a", eng_vec_a, ea);
        check_val("vec_b", eng_vec_b, eb);

        bad     = 0;
        n_quiet = (lat > 0) ? lat - 1 : TIMEOUT;
        for (int k = 0; k < n_quiet; k++) begin
            @(negedge clk);
            if (eng_start || m_valid || s_ready) bad++;
        end
        if (lat > 0) begin
            @(negedge clk);
            if (eng_start || m_valid || s_ready) bad++;
            check_val("vec_a_hold", eng_vec_a, ea);
            eng_similarity = eng_val;
            eng_valid      = 1'b1;
            @(negedge clk);
            eng_valid = 1'b0;
            check_val("result_rise", m_valid, 1);
            exp_d = eng_val;
            exp_s = {1'b0, sh};
        end else begin
            check_val("vec_a_hold", eng_vec_a, ea);
            @(negedge clk);
            check_val("timeout_rise", m_valid, 1);
            exp_d = QNAN;
            exp_s = {1'b1, sh};
            // Late engine answer while the result is pending must be ignored.
            eng_similarity = $urandom;
            eng_valid      = 1'b1;
            @(negedge clk);
            eng_valid = 1'b0;
        end
        check_val("wait_quiet", bad, 0);

        bad = 0;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            if (!m_valid || s_ready || m_data !== exp_d || m_status !== exp_s ||
                eng_vec_a !== ea || eng_vec_b !== eb) bad++;
        end
        check_val("bp_hold", bad, 0);
        check_val("m_data", m_data, exp_d);
        check_val("m_status", m_status, exp_s);

        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check_val("m_valid_drop", m_valid, 0);
        check_val("s_ready_back", s_ready, 1);
        check_val("buf_cleared", {eng_vec_a, eng_vec_b}, '0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]     fv[5];
        elem_t           e;
        logic [32*W-1:0] ea;
        logic [32*W-1:0] eb;
        bit              sh;
        int              r;
        int              lat;

        fv[0] = 32'h3F80_0000; fv[1] = 32'h4000_0000; fv[2] = 32'h4040_0000;
        fv[3] = 32'h4080_0000; fv[4] = 32'h40A0_0000;

        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
        eng_similarity = '0; eng_valid = 1'b0; m_ready = 1'b0;
        first_wait = 0;

        repeat (3) @(negedge clk);
        check_val("reset_outputs", {s_ready, eng_start, m_valid, m_data, m_status}, '0);
        check_val("reset_buffers", {eng_vec_a, eng_vec_b}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("s_ready_after_reset", s_ready, 1);

        // Full vector 1.0..5.0, engine answers 1.0 after 18 cycles
        for (int i = 0; i < 5; i++) begin
            e.a = fv[i]; e.b = fv[i]; e.last = (i == 4);
            pend.push_back(e);
        end
        do_vector(18, 0, 32'h3F80_0000);

        // Short vector of 3
        push_segment(3, 1);
        do_vector(10, 2, $urandom);

        // Engine never answers
        push_segment(5, 1);
        do_vector(-1, 1, 32'h0);

        // Backpressure with the next vector already waiting on the bus
        push_segment(5, 1);
        push_segment(4, 1);
        do_vector(5, 20, $urandom);
        do_vector(7, 0, $urandom);
        check_val("accept_after_ready", first_wait, 0);

        // Seven elements without last: 5 form a full vector, the rest wait
        push_segment(7, 0);
        push_segment(1, 1);
        do_vector(4, 3, $urandom);
        do_vector(4, 0, $urandom);

        // Engine answer on the same cycle as the timeout, and minimum latency
        push_segment(2, 1);
        do_vector(TIMEOUT, 0, $urandom);
        push_segment(5, 0);
        do_vector(1, 0, $urandom);

        // Random streams
        for (int it = 0; it < 30; it++) begin
            while (group_len() == 0) push_segment($urandom_range(1, 8), ($urandom % 2) == 1);
            r   = $urandom_range(0, 9);
            lat = (r == 0) ? -1 : $urandom_range(1, 40);
            do_vector(lat, $urandom_range(0, 5), $urandom);
        end

        // Reset while the engine is busy
        pend.delete();
        present_next();
        push_segment(5, 1);
        drive_group(ea, eb, sh);
        check_val("rst_test_start", eng_start, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outputs", {s_ready, eng_start, m_valid, m_data, m_status}, '0);
        check_val("rst_mid_buffers", {eng_vec_a, eng_vec_b}, '0);
        pend.delete();
        present_next();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("s_ready_after_rst_mid", s_ready, 1);
        push_segment(4, 1);
        do_vector(12, 1, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
